// File: rtl/fetch_next_pc_pkg.sv
// Shared types and constants for the instruction-fetch / next-PC stage.
package fetch_next_pc_pkg;

    localparam int PC_W_DEFAULT    = 64;
    localparam int INSTR_W_DEFAULT = 32;
    localparam int INSTR_BYTES     = 4;
    localparam int BR_SHIFT        = 2;

    // IDLE: one quiet cycle after reset; REQ: request outstanding; HOLD: word offered to decode
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        REQ  = 2'd1,
        HOLD = 2'd2
    } fetch_state_t;

endpackage

// File: rtl/next_pc_calc.sv
// Combinational next-PC arithmetic: branch decision, branch target and sequential PC.
module next_pc_calc
    import fetch_next_pc_pkg::*;
#(
    parameter int PC_W = PC_W_DEFAULT
) (
    input  logic [PC_W-1:0] pc,
    input  logic [PC_W-1:0] branch_pc,
    input  logic [PC_W-1:0] bus_imm,
    input  logic            branch,
    input  logic            uncondbranch,
    input  logic            alu_zero,
    output logic            taken,
    output logic [PC_W-1:0] target,
    output logic [PC_W-1:0] seq_pc
);

    // Branch resolution; all additions wrap modulo 2^PC_W, the immediate counts words.
    always_comb begin
        taken  = uncondbranch | (branch & alu_zero);
        target = branch_pc + (bus_imm << BR_SHIFT);
        seq_pc = pc + PC_W'(INSTR_BYTES);
    end

endmodule

// File: rtl/fetch_next_pc.sv
// Instruction-fetch and next-PC stage. Holds the PC, requests words from instruction
// memory, offers each word to decode and redirects on taken branches.
//
// Handshakes:
//   memory : ImemReq stays high while a fetch is wanted; the word is taken in the cycle
//            ImemAck is high. ImemAddr may change under ImemReq (memory then serves the
//            new address). ImemAck outside REQ is ignored.
//   decode : Instruction/InstrPC are stable while InstrValid is high; a transfer happens
//            on a cycle with InstrValid & InstrReady, unless a branch is taken that cycle,
//            in which case the held word is dropped.
module fetch_next_pc
    import fetch_next_pc_pkg::*;
#(
    parameter int PC_W    = PC_W_DEFAULT,
    parameter int INSTR_W = INSTR_W_DEFAULT,
    parameter int TIMEOUT = 255
) (
    input  logic               CLK,
    input  logic               Reset_L,
    input  logic [PC_W-1:0]    StartPC,
    output logic               ImemReq,
    output logic [PC_W-1:0]    ImemAddr,
    input  logic               ImemAck,
    input  logic [INSTR_W-1:0] ImemData,
    output logic [INSTR_W-1:0] Instruction,
    output logic [PC_W-1:0]    InstrPC,
    output logic               InstrValid,
    input  logic               InstrReady,
    input  logic               Branch,
    input  logic               Uncondbranch,
    input  logic               ALUZero,
    input  logic [PC_W-1:0]    BranchPC,
    input  logic [PC_W-1:0]    BusImm,
    output logic               FetchErr,
    output fetch_state_t       dbg_state
);

    localparam int CNT_W = (TIMEOUT < 1) ? 1 : $clog2(TIMEOUT + 1);
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(TIMEOUT);

    fetch_state_t     state;
    fetch_state_t     state_next;
    logic [PC_W-1:0]  pc;
    logic [PC_W-1:0]  target;
    logic [PC_W-1:0]  seq_pc;
    logic             taken;
    logic             accept;
    logic             cnt_inc;
    logic [CNT_W-1:0] cnt;
    logic [CNT_W-1:0] cnt_next;
    logic             fetch_err;

    next_pc_calc #(
        .PC_W (PC_W)
    ) u_next_pc_calc (
        .pc           (pc),
        .branch_pc    (BranchPC),
        .bus_imm      (BusImm),
        .branch       (Branch),
        .uncondbranch (Uncondbranch),
        .alu_zero     (ALUZero),
        .taken        (taken),
        .target       (target),
        .seq_pc       (seq_pc)
    );

    // A memory word is captured only in REQ and never in the cycle a redirect wins.
    assign accept  = (state == REQ) && ImemAck && !taken;
    assign cnt_inc = (state == REQ) && !ImemAck && !taken;

    assign ImemAddr = pc;
    assign FetchErr = fetch_err;

    // State register.
    always_ff @(posedge CLK) begin
        if (!Reset_L) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Next-state logic; a taken branch overrides every other event.
    always_comb begin
        state_next = state;
        if (taken) begin
            state_next = REQ;
        end else begin
            case (state)
                IDLE:    state_next = REQ;
                REQ:     if (ImemAck) state_next = HOLD;
                HOLD:    if (InstrReady) state_next = REQ;
                default: state_next = IDLE;
            endcase
        end
    end

    // State-decoded outputs.
    always_comb begin
        ImemReq    = (state == REQ);
        InstrValid = (state == HOLD);
        dbg_state  = state;
    end

    // Wait counter: counts unanswered REQ cycles, saturates at TIMEOUT, clears otherwise.
    always_comb begin
        cnt_next = '0;
        if (cnt_inc) begin
            cnt_next = (cnt == CNT_MAX) ? cnt : cnt + CNT_W'(1);
        end
    end

    // PC and fetched-word registers.
    always_ff @(posedge CLK) begin
        if (!Reset_L) begin
            pc          <= {StartPC[PC_W-1:2], 2'b00};
            Instruction <= '0;
            InstrPC     <= '0;
        end else if (taken) begin
            pc <= target;
        end else if (accept) begin
            pc          <= seq_pc;
            Instruction <= ImemData;
            InstrPC     <= pc;
        end
    end

    // Timeout counter and sticky error flag; the flag rises as the count reaches TIMEOUT.
    always_ff @(posedge CLK) begin
        if (!Reset_L) begin
            cnt       <= '0;
            fetch_err <= 1'b0;
        end else begin
            cnt       <= cnt_next;
            fetch_err <= fetch_err | (cnt_inc && (cnt_next == CNT_MAX));
        end
    end

endmodule

// File: tb/tb_fetch_next_pc.sv
// Bench for fetch_next_pc: directed scenarios plus a randomized run against a
// transaction-level reference model.
module tb_fetch_next_pc;
    import fetch_next_pc_pkg::*;

    localparam int TMO = 4;

    logic         CLK = 1'b0;
    logic         Reset_L = 1'b0;
    logic [63:0]  StartPC = '0;
    logic         ImemReq;
    logic [63:0]  ImemAddr;
    logic         ImemAck = 1'b0;
    logic [31:0]  ImemData = '0;
    logic [31:0]  Instruction;
    logic [63:0]  InstrPC;
    logic         InstrValid;
    logic         InstrReady = 1'b1;
    logic         Branch = 1'b0;
    logic         Uncondbranch = 1'b0;
    logic         ALUZero = 1'b0;
    logic [63:0]  BranchPC = '0;
    logic [63:0]  BusImm = '0;
    logic         FetchErr;
    fetch_state_t dbg_state;

    int checks = 0;
    int errors = 0;
    logic [31:0] last_word;

    // reference model
    logic [63:0] m_pc, m_ipc;
    logic [31:0] m_instr;
    bit          m_idle, m_req, m_valid, m_err;
    int          m_wait;

    fetch_next_pc #(.PC_W(64), .INSTR_W(32), .TIMEOUT(TMO)) dut (
        .CLK(CLK), .Reset_L(Reset_L), .StartPC(StartPC),
        .ImemReq(ImemReq), .ImemAddr(ImemAddr), .ImemAck(ImemAck), .ImemData(ImemData),
        .Instruction(Instruction), .InstrPC(InstrPC), .InstrValid(InstrValid),
        .InstrReady(InstrReady), .Branch(Branch), .Uncondbranch(Uncondbranch),
        .ALUZero(ALUZero), .BranchPC(BranchPC), .BusImm(BusImm),
        .FetchErr(FetchErr), .dbg_state(dbg_state)
    );

    // clock
    always #5 CLK = ~CLK;

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    task automatic apply_reset(input logic [63:0] start, input int n);
        StartPC = start;
        Reset_L = 1'b0;
        repeat (n) tick();
        Reset_L = 1'b1;
    endtask

    task automatic test_reset();
        ImemAck = 1'b1;
        ImemData = 32'h1234_5678;
        apply_reset(64'h1003, 2);
        ImemAck = 1'b0;
        checks++; if (ImemReq !== 1'b0) begin errors++; $display("FAIL reset_req: got %b expected 0", ImemReq); end
        checks++; if (ImemAddr !== 64'h1000) begin errors++; $display("FAIL reset_addr: got %h expected 1000", ImemAddr); end
        checks++; if (InstrValid !== 1'b0) begin errors++; $display("FAIL reset_valid: got %b expected 0", InstrValid); end
        checks++; if (Instruction !== 32'h0) begin errors++; $display("FAIL reset_instr: got %h expected 0", Instruction); end
        checks++; if (InstrPC !== 64'h0) begin errors++; $display("FAIL reset_instrpc: got %h expected 0", InstrPC); end
        checks++; if (FetchErr !== 1'b0) begin errors++; $display("FAIL reset_err: got %b expected 0", FetchErr); end
        checks++; if (dbg_state !== IDLE) begin errors++; $display("FAIL reset_state: got %0d expected IDLE", dbg_state); end
    endtask

    task automatic test_seq_fetch();
        logic [31:0] d;
        InstrReady = 1'b1;
        tick();  // IDLE -> REQ
        for (int k = 0; k < 3; k++) begin
            checks++; if (ImemReq !== 1'b1) begin errors++; $display("FAIL seq_req[%0d]: got %b expected 1", k, ImemReq); end
            checks++; if (ImemAddr !== 64'h1000 + 64'(4 * k)) begin errors++; $display("FAIL seq_addr[%0d]: got %h expected %h", k, ImemAddr, 64'h1000 + 64'(4 * k)); end
            checks++; if (InstrValid !== 1'b0) begin errors++; $display("FAIL seq_valid_low[%0d]: got %b expected 0", k, InstrValid); end
            d = $urandom;
            ImemAck = 1'b1;
            ImemData = d;
            tick();
            ImemAck = 1'b0;
            checks++; if (InstrValid !== 1'b1) begin errors++; $display("FAIL seq_valid[%0d]: got %b expected 1", k, InstrValid); end
            checks++; if (Instruction !== d) begin errors++; $display("FAIL seq_instr[%0d]: got %h expected %h", k, Instruction, d); end
            checks++; if (InstrPC !== 64'h1000 + 64'(4 * k)) begin errors++; $display("FAIL seq_instrpc[%0d]: got %h expected %h", k, InstrPC, 64'h1000 + 64'(4 * k)); end
            checks++; if (ImemReq !== 1'b0) begin errors++; $display("FAIL seq_req_hold[%0d]: got %b expected 0", k, ImemReq); end
            tick();
        end
    endtask

    task automatic test_backpressure();
        logic [31:0] d;
        d = $urandom;
        InstrReady = 1'b0;
        ImemAck = 1'b1;
        ImemData = d;
        tick();
        for (int k = 0; k < 5; k++) begin
            checks++; if (InstrValid !== 1'b1) begin errors++; $display("FAIL bp_valid[%0d]: got %b expected 1", k, InstrValid); end
            checks++; if (Instruction !== d) begin errors++; $display("FAIL bp_instr[%0d]: got %h expected %h", k, Instruction, d); end
            checks++; if (InstrPC !== 64'h100C) begin errors++; $display("FAIL bp_instrpc[%0d]: got %h expected 100c", k, InstrPC); end
            checks++; if (ImemReq !== 1'b0) begin errors++; $display("FAIL bp_req[%0d]: got %b expected 0", k, ImemReq); end
            ImemAck = 1'($urandom_range(0, 1));  // stray acks in HOLD must be ignored
            ImemData = $urandom;
            tick();
        end
        ImemAck = 1'b0;
        InstrReady = 1'b1;
        tick();
        checks++; if (ImemReq !== 1'b1) begin errors++; $display("FAIL bp_release_req: got %b expected 1", ImemReq); end
        checks++; if (ImemAddr !== 64'h1010) begin errors++; $display("FAIL bp_release_addr: got %h expected 1010", ImemAddr); end
        checks++; if (InstrValid !== 1'b0) begin errors++; $display("FAIL bp_release_valid: got %b expected 0", InstrValid); end
    endtask

    task automatic test_backward_branch();
        Uncondbranch = 1'b1;
        BranchPC = 64'h2000;
        BusImm = 64'hFFFF_FFFF_FFFF_FFFE;
        tick();
        Uncondbranch = 1'b0;
        checks++; if (ImemAddr !== 64'h1FF8) begin errors++; $display("FAIL bwd_addr: got %h expected 1ff8", ImemAddr); end
        checks++; if (InstrValid !== 1'b0) begin errors++; $display("FAIL bwd_valid: got %b expected 0", InstrValid); end
        checks++; if (ImemReq !== 1'b1) begin errors++; $display("FAIL bwd_req: got %b expected 1", ImemReq); end
    endtask

    task automatic test_cond_branch();
        last_word = $urandom;
        Branch = 1'b1;
        ALUZero = 1'b0;
        BranchPC = 64'h40;
        BusImm = 64'h10;
        ImemAck = 1'b1;
        ImemData = last_word;
        tick();
        ImemAck = 1'b0;
        checks++; if (InstrValid !== 1'b1) begin errors++; $display("FAIL nt_valid: got %b expected 1", InstrValid); end
        checks++; if (InstrPC !== 64'h1FF8) begin errors++; $display("FAIL nt_instrpc: got %h expected 1ff8", InstrPC); end
        checks++; if (ImemAddr !== 64'h1FFC) begin errors++; $display("FAIL nt_addr: got %h expected 1ffc", ImemAddr); end
        ALUZero = 1'b1;
        InstrReady = 1'b1;  // held word is dropped despite ready
        tick();
        Branch = 1'b0;
        ALUZero = 1'b0;
        checks++; if (ImemAddr !== 64'h80) begin errors++; $display("FAIL tk_addr: got %h expected 80", ImemAddr); end
        checks++; if (InstrValid !== 1'b0) begin errors++; $display("FAIL tk_valid: got %b expected 0", InstrValid); end
        checks++; if (ImemReq !== 1'b1) begin errors++; $display("FAIL tk_req: got %b expected 1", ImemReq); end
    endtask

    task automatic test_redirect_ack();
        Uncondbranch = 1'b1;
        BranchPC = 64'h3000;
        BusImm = 64'h3;
        ImemAck = 1'b1;
        ImemData = ~last_word;
        tick();
        Uncondbranch = 1'b0;
        ImemAck = 1'b0;
        checks++; if (ImemAddr !== 64'h300C) begin errors++; $display("FAIL rda_addr: got %h expected 300c", ImemAddr); end
        checks++; if (InstrValid !== 1'b0) begin errors++; $display("FAIL rda_valid: got %b expected 0", InstrValid); end
        checks++; if (Instruction !== last_word) begin errors++; $display("FAIL rda_instr: got %h expected %h", Instruction, last_word); end
        tick();
        checks++; if (ImemAddr !== 64'h300C || ImemReq !== 1'b1) begin errors++; $display("FAIL rda_retry: got addr %h req %b expected 300c 1", ImemAddr, ImemReq); end
    endtask

    task automatic test_timeout();
        apply_reset(64'h500, 1);
        ImemAck = 1'b0;
        tick();  // first REQ cycle
        for (int n = 1; n <= 9; n++) begin
            checks++; if (FetchErr !== (n >= TMO + 1)) begin errors++; $display("FAIL tmo_err[cycle %0d]: got %b expected %b", n, FetchErr, n >= TMO + 1); end
            checks++; if (ImemReq !== 1'b1) begin errors++; $display("FAIL tmo_req[cycle %0d]: got %b expected 1", n, ImemReq); end
            tick();
        end
        ImemAck = 1'b1;
        tick();
        ImemAck = 1'b0;
        checks++; if (FetchErr !== 1'b1 || InstrValid !== 1'b1) begin errors++; $display("FAIL tmo_sticky: got err %b valid %b expected 1 1", FetchErr, InstrValid); end
        Reset_L = 1'b0;
        tick();
        Reset_L = 1'b1;
        checks++; if (FetchErr !== 1'b0) begin errors++; $display("FAIL tmo_clear: got %b expected 0", FetchErr); end
    endtask

    task automatic test_wrap();
        apply_reset(64'hFFFF_FFFF_FFFF_FFFC, 1);
        InstrReady = 1'b1;
        tick();
        checks++; if (ImemAddr !== 64'hFFFF_FFFF_FFFF_FFFC) begin errors++; $display("FAIL wrap_first: got %h expected fffffffffffffffc", ImemAddr); end
        ImemAck = 1'b1;
        ImemData = $urandom;
        tick();
        ImemAck = 1'b0;
        tick();
        checks++; if (ImemAddr !== 64'h0 || ImemReq !== 1'b1) begin errors++; $display("FAIL wrap_second: got addr %h req %b expected 0 1", ImemAddr, ImemReq); end
    endtask

    // One cycle of the reference model, evaluated on the inputs about to be sampled.
    task automatic model_step();
        bit tk;
        tk = Uncondbranch | (Branch & ALUZero);
        if (!Reset_L) begin
            m_pc = StartPC & ~64'h3;
            m_ipc = '0; m_instr = '0;
            m_idle = 1; m_req = 0; m_valid = 0; m_err = 0; m_wait = 0;
        end else if (tk) begin
            m_pc = BranchPC + BusImm * 64'd4;
            m_idle = 0; m_req = 1; m_valid = 0; m_wait = 0;
        end else if (m_idle) begin
            m_idle = 0; m_req = 1;
        end else if (m_req) begin
            if (ImemAck) begin
                m_instr = ImemData; m_ipc = m_pc; m_pc = m_pc + 64'd4;
                m_req = 0; m_valid = 1; m_wait = 0;
            end else begin
                if (m_wait < TMO) m_wait++;
                if (m_wait == TMO) m_err = 1;
            end
        end else if (m_valid && InstrReady) begin
            m_valid = 0; m_req = 1;
        end
    endtask

    task automatic test_random();
        for (int i = 0; i < 3000; i++) begin
            Reset_L = (i == 0) ? 1'b0 : ($urandom_range(0, 99) >= 2);
            StartPC = {$urandom, $urandom};
            ImemAck = ($urandom_range(0, 9) < 6);
            ImemData = $urandom;
            InstrReady = ($urandom_range(0, 9) < 7);
            Uncondbranch = ($urandom_range(0, 15) == 0);
            Branch = ($urandom_range(0, 7) == 0);
            ALUZero = 1'($urandom_range(0, 1));
            BranchPC = {$urandom, $urandom};
            BusImm = ($urandom_range(0, 1) == 1) ? {$urandom, $urandom} : 64'($signed(16'($urandom)));
            model_step();
            tick();
            checks++; if (ImemReq !== m_req) begin errors++; $display("FAIL rnd_req[%0d]: got %b expected %b", i, ImemReq, m_req); end
            checks++; if (ImemAddr !== m_pc) begin errors++; $display("FAIL rnd_addr[%0d]: got %h expected %h", i, ImemAddr, m_pc); end
            checks++; if (InstrValid !== m_valid) begin errors++; $display("FAIL rnd_valid[%0d]: got %b expected %b", i, InstrValid, m_valid); end
            checks++; if (FetchErr !== m_err) begin errors++; $display("FAIL rnd_err[%0d]: got %b expected %b", i, FetchErr, m_err); end
            if (m_valid) begin
                checks++; if (Instruction !== m_instr) begin errors++; $display("FAIL rnd_instr[%0d]: got %h expected %h", i, Instruction, m_instr); end
                checks++; if (InstrPC !== m_ipc) begin errors++; $display("FAIL rnd_instrpc[%0d]: got %h expected %h", i, InstrPC, m_ipc); end
            end
        end
        Reset_L = 1'b1;
        Uncondbranch = 1'b0;
        Branch = 1'b0;
    endtask

    initial begin
        test_reset();
        test_seq_fetch();
        test_backpressure();
        test_backward_branch();
        test_cond_branch();
        test_redirect_ack();
        test_timeout();
        test_wrap();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/fetch_next_pc.md
Name: fetch_next_pc

Overview:
- Instruction-fetch and next-PC stage of the processor.
- Holds the PC and issues requests to instruction memory over a variable-latency request/ack handshake.
- Presents each fetched word to decode, which feeds the immediate sign extender, using a valid/ready handshake.
- Consumes the resolved branch outcome and the 64-bit sign-extended immediate (BusImm) to redirect the PC.

Parameters:
PC_W, 64, PC and address width
INSTR_W, 32, instruction word width
TIMEOUT, 255, max cycles ImemReq may stay high without ImemAck before FetchErr asserts

Ports:
CLK  in  1  clock, all state updates on rising edge
Reset_L  in  1  reset, synchronous, active-low
StartPC  in  PC_W  PC loaded while Reset_L=0
ImemReq  out  1  fetch request to instruction memory
ImemAddr  out  PC_W  fetch address (=PC)
ImemAck  in  1  memory returns ImemData this cycle
ImemData  in  INSTR_W  fetched word
Instruction  out  INSTR_W  word presented to decode
InstrPC  out  PC_W  address of Instruction
InstrValid  out  1  Instruction valid
InstrReady  in  1  decode accepts Instruction
Branch  in  1  conditional branch in execute (CBZ/CBNZ/B.cond)
Uncondbranch  in  1  B/BL in execute
ALUZero  in  1  condition result for Branch
BranchPC  in  PC_W  PC of the branching instruction
BusImm  in  PC_W  sign-extended word offset from the sign extender
FetchErr  out  1  sticky memory-timeout flag

Behaviour:
- Reset is sampled at the clock edge while Reset_L=0. Reset values:
  - PC=StartPC with bits [1:0] forced to 0
  - state=IDLE
  - ImemReq=0
  - Instruction=0, InstrPC=0, InstrValid=0
  - FetchErr=0, timeout counter=0
- Reset asserted mid-request abandons the request. Any later ImemAck is ignored until state=REQ.
- Taken = Uncondbranch | (Branch & ALUZero).
- Target = BranchPC + (BusImm << 2), computed modulo 2^PC_W. BusImm is two's complement.
- Sequential PC: PC+4, wrapping modulo 2^PC_W (all-ones-minus-3 wraps to 0).
- ImemAddr = PC combinationally at all times.
- ImemReq = 1 exactly when state=REQ.
- States and transitions:
  - IDLE: ImemReq=0. Goes to REQ on the next cycle.
  - REQ: ImemReq=1.
    - ImemAck=1 sampled: Instruction<=ImemData, InstrPC<=PC, InstrValid<=1, PC<=PC+4, go to HOLD.
    - Zero-wait ack in the same cycle ImemReq first rises is legal.
  - HOLD: ImemReq=0, InstrValid=1, Instruction and InstrPC stable.
    - InstrReady=1: InstrValid<=0, go to REQ. No bubble beyond the one REQ cycle.
- Redirect (Taken=1) has priority over every other event, in any non-reset state:
  - PC<=Target, InstrValid<=0, state<=REQ.
  - An ImemAck in the same cycle is discarded: Instruction is not updated, and PC is not incremented.
  - A held Instruction in HOLD is dropped, even if InstrReady=1 that cycle. Decode must not consume a word it sees with Taken high.
  - The memory contract allows ImemAddr to change while ImemReq stays high. Memory abandons the old request and serves the new address.
- Timeout counter:
  - Increments each cycle in REQ without ImemAck.
  - Clears on ack, redirect, or leaving REQ.
  - At count==TIMEOUT, FetchErr<=1. FetchErr is sticky until reset, and fetching continues.
  - The counter saturates and never wraps.
- ImemAck outside REQ is ignored.
- Latency: fetched word is visible on Instruction the cycle after ack. Minimum fetch-to-fetch interval is 2 cycles (REQ+HOLD).

Decomposition:
- Shared package holds:
  - state enum: IDLE, REQ, HOLD
  - INSTR_BYTES=4
  - BR_SHIFT=2
  - PC_W default
- One combinational sub-module, next_pc_calc:
  - inputs: PC, BranchPC, BusImm, Branch, Uncondbranch, ALUZero
  - outputs: Taken, Target, SeqPC
- The FSM, registers and timeout counter stay in fetch_next_pc.

Test Plan:
- Reset and sequential fetch: StartPC=0x1003, Reset_L low 2 cycles then high; memory acks next cycle, InstrReady=1.
  -> ImemAddr=0x1000, then 0x1004, then 0x1008. InstrPC tracks each. InstrValid pulses one cycle per word.
- Backpressure: InstrReady=0 for 5 cycles after a fetch.
  -> Instruction/InstrPC held constant, InstrValid=1, ImemReq=0 throughout.
  -> Next request issues the cycle after InstrReady=1.
- Backward branch: Uncondbranch=1, BranchPC=0x2000, BusImm=0xFFFF_FFFF_FFFF_FFFE.
  -> Next ImemAddr=0x1FF8 and InstrValid=0 the following cycle.
- Conditional branch, both outcomes, with BranchPC=0x40, BusImm=0x10:
  - Branch=1, ALUZero=0 -> sequential fetch continues.
  - Branch=1, ALUZero=1 -> ImemAddr=0x80.
- Redirect colliding with ack: Taken and ImemAck high in the same cycle.
  -> ack data discarded, InstrValid stays 0, ImemAddr becomes Target.
- Timeout: TIMEOUT=4, memory never acks.
  -> FetchErr=1 on the 5th REQ cycle and remains 1.
  -> Reset_L low for one cycle clears FetchErr.
- Wrap: StartPC=0xFFFF_FFFF_FFFF_FFFC.
  -> second fetch address is 0x0.
